// File: rtl/adc_frame_packer.sv
// adc_frame_packer: captures 128-sample ADC frames into a ping-pong buffer
// and re-emits them as sync/id/data/checksum byte packets on a valid/ready link.
module adc_frame_packer #(
    parameter int          NUM_CH = 128,
    parameter logic [7:0]  SYNC0  = 8'hA5,
    parameter logic [7:0]  SYNC1  = 8'h5A
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] drop_cnt,
    output logic       frame_err,
    output logic       busy
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {W_IDLE, W_CAP, W_SKIP} w_state_t;
    typedef enum logic [2:0] {
        R_IDLE, R_SYNC0, R_SYNC1, R_ID, R_DATA, R_CHK
    } r_state_t;

    logic [7:0]      mem [2][NUM_CH];
    logic [1:0]      bank_full;
    logic [1:0][7:0] bank_tag;

    w_state_t        w_state, w_next;
    logic            in_valid_d;
    logic            rise;
    logic            wr_bank;
    logic [IW-1:0]   wr_idx;
    logic [7:0]      frame_id;
    logic            wr_we, w_done, w_abort, w_drop;

    r_state_t        r_state, r_next;
    logic            rd_bank;
    logic [IW-1:0]   rd_idx, rd_idx_next, rd_addr;
    logic [7:0]      chk, chk_next;
    logic [7:0]      rd_byte;
    logic [7:0]      od_next;
    logic            ov_next;
    logic            rd_free;
    logic            accept;

    // A frame starts only on a genuine low-to-high edge of in_valid
    assign rise   = in_valid & ~in_valid_d;
    assign accept = out_valid & out_ready;
    assign busy   = (|bank_full) | (r_state != R_IDLE);

    // Write-side next state and capture strobes
    always_comb begin
        w_next  = w_state;
        wr_we   = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        w_drop  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (rise && enable) begin
                    if (!bank_full[wr_bank]) begin
                        wr_we  = 1'b1;
                        w_next = W_CAP;
                    end else begin
                        w_drop = 1'b1;
                        w_next = W_SKIP;
                    end
                end
            end
            W_CAP: begin
                if (in_valid) begin
                    wr_we = 1'b1;
                    if (wr_idx == LAST) begin
                        w_done = 1'b1;
                        w_next = W_IDLE;
                    end
                end else begin
                    w_abort = 1'b1;
                    w_next  = W_IDLE;
                end
            end
            W_SKIP: begin
                if (!in_valid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write-side state, index, frame counter and error/drop bookkeeping
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            w_state    <= W_IDLE;
            in_valid_d <= 1'b1;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            frame_id   <= 8'd0;
            drop_cnt   <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            w_state    <= w_next;
            in_valid_d <= in_valid;
            if (wr_we) wr_idx <= w_done ? '0 : wr_idx + IW'(1);
            if (w_abort) begin
                wr_idx    <= '0;
                frame_err <= 1'b1;
            end
            if (w_done) begin
                frame_id <= frame_id + 8'd1;
                wr_bank  <= ~wr_bank;
            end
            if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Sample storage; contents need no reset since full flags gate reads
    always_ff @(posedge clk) begin
        if (wr_we) mem[wr_bank][wr_idx] <= in_data;
    end

    // Bank ownership: write side fills, read side frees (never the same bank)
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bank_full <= 2'b00;
            bank_tag  <= '0;
        end else begin
            if (w_done) begin
                bank_full[wr_bank] <= 1'b1;
                bank_tag[wr_bank]  <= frame_id;
            end
            if (rd_free) bank_full[rd_bank] <= 1'b0;
        end
    end

    // Read-side next state, next output byte and running checksum
    always_comb begin
        r_next      = r_state;
        od_next     = out_data;
        ov_next     = out_valid;
        chk_next    = chk;
        rd_idx_next = rd_idx;
        rd_free     = 1'b0;
        rd_addr     = (r_state == R_DATA) ? rd_idx + IW'(1) : '0;
        rd_byte     = mem[rd_bank][rd_addr];
        unique case (r_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) begin
                    od_next = SYNC0;
                    ov_next = 1'b1;
                    r_next  = R_SYNC0;
                end
            end
            R_SYNC0: begin
                if (accept) begin
                    od_next = SYNC1;
                    r_next  = R_SYNC1;
                end
            end
            R_SYNC1: begin
                if (accept) begin
                    od_next  = bank_tag[rd_bank];
                    chk_next = bank_tag[rd_bank];
                    r_next   = R_ID;
                end
            end
            R_ID: begin
                if (accept) begin
                    od_next     = rd_byte;
                    chk_next    = chk + rd_byte;
                    rd_idx_next = '0;
                    r_next      = R_DATA;
                end
            end
            R_DATA: begin
                if (accept) begin
                    if (rd_idx == LAST) begin
                        od_next = chk;
                        r_next  = R_CHK;
                    end else begin
                        od_next     = rd_byte;
                        chk_next    = chk + rd_byte;
                        rd_idx_next = rd_idx + IW'(1);
                    end
                end
            end
            R_CHK: begin
                if (accept) begin
                    ov_next = 1'b0;
                    rd_free = 1'b1;
                    r_next  = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read-side registers; output byte is held stable while stalled
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= R_IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            chk       <= 8'd0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            r_state   <= r_next;
            rd_idx    <= rd_idx_next;
            chk       <= chk_next;
            out_data  <= od_next;
            out_valid <= ov_next;
            if (rd_free) rd_bank <= ~rd_bank;
        end
    end

endmodule
